// File: rtl/ysyx_lsu_pkg.sv
// Shared types, funct3 encodings and lane helpers for the ysyx load/store unit.
package ysyx_lsu_pkg;

  localparam int BIT_W   = 32;
  localparam int FAULT_W = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WRESP = 3'd4,
    DONE  = 3'd5
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Unshifted byte-enable mask for the access size encoded in funct3[1:0].
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_lsu_align.sv
// Combinational byte-lane steering: store strobe/data placement and load shift plus extension.
// Lanes shifted past byte 3 are dropped.
module ysyx_lsu_align
  import ysyx_lsu_pkg::*;
(
  input  logic [2:0]       func3,
  input  logic [1:0]       a,
  input  logic [BIT_W-1:0] rdata_raw,
  input  logic [BIT_W-1:0] wdata,
  output logic [3:0]       wstrb,
  output logic [BIT_W-1:0] wdata_sh,
  output logic [BIT_W-1:0] rdata_ext
);

  logic [4:0]       shamt;
  logic [BIT_W-1:0] rsh;

  assign shamt    = {a, 3'b000};
  assign rsh      = rdata_raw >> shamt;
  assign wdata_sh = wdata << shamt;
  assign wstrb    = size_mask(func3) << a;

  always_comb begin
    case (func3)
      F3_LB:   rdata_ext = {{(BIT_W-8){rsh[7]}}, rsh[7:0]};
      F3_LH:   rdata_ext = {{(BIT_W-16){rsh[15]}}, rsh[15:0]};
      F3_LBU:  rdata_ext = {{(BIT_W-8){1'b0}}, rsh[7:0]};
      F3_LHU:  rdata_ext = {{(BIT_W-16){1'b0}}, rsh[15:0]};
      default: rdata_ext = rsh;
    endcase
  end

endmodule

// File: rtl/ysyx_lsu.sv
// Load/store unit: one execute request becomes one AXI4-Lite-style read or write, 3 cycles on a zero-wait bus.
// Define YSYX_LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of issuing them.
module ysyx_lsu
  import ysyx_lsu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               lsu_avalid_i,
  input  logic               ren_i,
  input  logic               wen_i,
  input  logic [2:0]         func3_i,
  input  logic [BIT_W-1:0]   addr_i,
  input  logic [BIT_W-1:0]   wdata_i,
  output logic [BIT_W-1:0]   rdata_o,
  output logic               rvalid_o,
  output logic               wready_o,
  output logic [FAULT_W-1:0] fault_o,
  output logic [BIT_W-1:0]   araddr_o,
  output logic               arvalid_o,
  input  logic               arready_i,
  input  logic [BIT_W-1:0]   rdata_i,
  input  logic [1:0]         rresp_i,
  input  logic               rvalid_i,
  output logic               rready_o,
  output logic [BIT_W-1:0]   awaddr_o,
  output logic               awvalid_o,
  input  logic               awready_i,
  output logic [BIT_W-1:0]   wdata_bus_o,
  output logic [3:0]         wstrb_o,
  output logic               wvalid_o,
  input  logic               wready_i,
  input  logic [1:0]         bresp_i,
  input  logic               bvalid_i,
  output logic               bready_o
);

  lsu_state_e       state;
  logic [2:0]       func3_q;
  logic [BIT_W-1:0] addr_q;
  logic [BIT_W-1:0] wdata_q;
  logic             aw_done;
  logic             w_done;
  logic             aw_ok;
  logic             w_ok;
  logic [BIT_W-1:0] rdata_ext;
  logic             unused_resp;

  assign unused_resp = ^{rresp_i, bresp_i};

  ysyx_lsu_align u_align (
    .func3     (func3_q),
    .a         (addr_q[1:0]),
    .rdata_raw (rdata_i),
    .wdata     (wdata_q),
    .wstrb     (wstrb_o),
    .wdata_sh  (wdata_bus_o),
    .rdata_ext (rdata_ext)
  );

  assign araddr_o = {addr_q[BIT_W-1:2], 2'b00};
  assign awaddr_o = {addr_q[BIT_W-1:2], 2'b00};

  // A beat counts as accepted if it was remembered earlier or handshakes this cycle.
  assign aw_ok = aw_done | (awvalid_o & awready_i);
  assign w_ok  = w_done  | (wvalid_o  & wready_i);

`ifndef YSYX_LSU_MISALIGN_TRAP_EN
  assign fault_o = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      func3_q   <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rdata_o   <= '0;
      rvalid_o  <= 1'b0;
      wready_o  <= 1'b0;
      arvalid_o <= 1'b0;
      rready_o  <= 1'b0;
      awvalid_o <= 1'b0;
      wvalid_o  <= 1'b0;
      bready_o  <= 1'b0;
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
      fault_o   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (lsu_avalid_i && (ren_i || wen_i)) begin
            func3_q <= func3_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
            if (misaligned(func3_i, addr_i[1:0])) begin
              state    <= DONE;
              rvalid_o <= ren_i;
              wready_o <= !ren_i;
              fault_o  <= '1;
            end else
`endif
            if (ren_i) begin
              state     <= RADDR;
              arvalid_o <= 1'b1;
            end else begin
              state     <= WREQ;
              awvalid_o <= 1'b1;
              wvalid_o  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
            end
          end
        end
        RADDR: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            state     <= RDATA;
          end
        end
        RDATA: begin
          if (rvalid_i) begin
            rready_o <= 1'b0;
            rdata_o  <= rdata_ext;
            rvalid_o <= 1'b1;
            state    <= DONE;
          end
        end
        WREQ: begin
          if (awvalid_o && awready_i) begin
            awvalid_o <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (wvalid_o && wready_i) begin
            wvalid_o <= 1'b0;
            w_done   <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            bready_o <= 1'b1;
            state    <= WRESP;
          end
        end
        WRESP: begin
          if (bvalid_i) begin
            bready_o <= 1'b0;
            wready_o <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          rvalid_o <= 1'b0;
          wready_o <= 1'b0;
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
          fault_o  <= '0;
`endif
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_lsu.sv
// Directed bench for ysyx_lsu: loads, stores with varied AW/W ordering, mid-transfer reset, misalignment.
module tb_ysyx_lsu;
  import ysyx_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lsu_avalid_i = 1'b0, ren_i = 1'b0, wen_i = 1'b0;
  logic [2:0]  func3_i = 3'b000;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [31:0] rdata_o;
  logic        rvalid_o, wready_o;
  logic [0:0]  fault_o;
  logic [31:0] araddr_o;
  logic        arvalid_o;
  logic        arready_i = 1'b0;
  logic [31:0] rdata_i = '0;
  logic [1:0]  rresp_i = 2'b00;
  logic        rvalid_i = 1'b0;
  logic        rready_o;
  logic [31:0] awaddr_o;
  logic        awvalid_o;
  logic        awready_i = 1'b0;
  logic [31:0] wdata_bus_o;
  logic [3:0]  wstrb_o;
  logic        wvalid_o;
  logic        wready_i = 1'b0;
  logic [1:0]  bresp_i = 2'b00;
  logic        bvalid_i = 1'b0;
  logic        bready_o;

  int n_checks = 0;
  int n_fail   = 0;
  int aw_cnt   = 0;
  int w_cnt    = 0;

  ysyx_lsu u_dut (
    .clk(clk), .rst(rst), .lsu_avalid_i(lsu_avalid_i), .ren_i(ren_i), .wen_i(wen_i),
    .func3_i(func3_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .rvalid_o(rvalid_o), .wready_o(wready_o), .fault_o(fault_o),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_bus_o(wdata_bus_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (awvalid_o && awready_i) aw_cnt = aw_cnt + 1;
    if (wvalid_o && wready_i)   w_cnt  = w_cnt + 1;
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_valids got %b want 00000", {arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o});
    end
    n_checks++;
    if ({rvalid_o, wready_o, fault_o} !== 3'b0) begin
      n_fail++; $display("FAIL reset_pulses got %b want 000", {rvalid_o, wready_o, fault_o});
    end
    n_checks++;
    if (rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata got %h want 00000000", rdata_o);
    end
    rst = 1'b1;
  endtask

  task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] word, input logic [31:0] exp);
    int lat;
    lat = 0;
    @(negedge clk);
    lsu_avalid_i = 1'b1; ren_i = 1'b1; wen_i = 1'b0; func3_i = f3; addr_i = addr;
    arready_i = 1'b1; rvalid_i = 1'b0; rdata_i = word;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        addr_i = 32'h0; func3_i = 3'b111;
        n_checks++;
        if (arvalid_o !== 1'b1 || araddr_o !== {addr[31:2], 2'b00}) begin
          n_fail++; $display("FAIL %s_ar got vld=%b addr=%h want vld=1 addr=%h", name, arvalid_o, araddr_o, {addr[31:2], 2'b00});
        end
      end
      if (rvalid_o) begin lat = n; break; end
      rvalid_i = rready_o;
    end
    lsu_avalid_i = 1'b0; ren_i = 1'b0; rvalid_i = 1'b0;
    n_checks++;
    if (lat != 3) begin
      n_fail++; $display("FAIL %s_latency got %0d want 3", name, lat);
    end
    n_checks++;
    if (rdata_o !== exp || fault_o !== 1'b0) begin
      n_fail++; $display("FAIL %s_data got %h fault=%b want %h fault=0", name, rdata_o, fault_o, exp);
    end
    @(negedge clk);
    n_checks++;
    if (rvalid_o !== 1'b0 || rdata_o !== exp) begin
      n_fail++; $display("FAIL %s_pulse_hold got rvalid=%b data=%h want rvalid=0 data=%h", name, rvalid_o, rdata_o, exp);
    end
    arready_i = 1'b0;
  endtask

  task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input int aw_dly, input int w_dly,
                            input logic [3:0] exp_strb, input logic [31:0] exp_dat);
    int lat, b_at, exp_lat;
    lat = 0; b_at = -1;
    exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly);
    @(negedge clk);
    aw_cnt = 0; w_cnt = 0;
    lsu_avalid_i = 1'b1; wen_i = 1'b1; ren_i = 1'b0; func3_i = f3; addr_i = addr; wdata_i = wd;
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        addr_i = 32'h0; wdata_i = 32'h0; func3_i = 3'b111;
        n_checks++;
        if (wstrb_o !== exp_strb || wdata_bus_o !== exp_dat || awaddr_o !== {addr[31:2], 2'b00}) begin
          n_fail++; $display("FAIL %s_lanes got strb=%b data=%h aw=%h want strb=%b data=%h aw=%h",
                             name, wstrb_o, wdata_bus_o, awaddr_o, exp_strb, exp_dat, {addr[31:2], 2'b00});
        end
      end
      if (wready_o) begin lat = n; break; end
      awready_i = (n - 1 >= aw_dly);
      wready_i  = (n - 1 >= w_dly);
      bvalid_i  = bready_o;
      if (bready_o && b_at < 0) b_at = n;
    end
    lsu_avalid_i = 1'b0; wen_i = 1'b0; awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
    n_checks++;
    if (lat != exp_lat || b_at != lat - 1) begin
      n_fail++; $display("FAIL %s_latency got lat=%0d bvalid_at=%0d want lat=%0d bvalid_at=%0d", name, lat, b_at, exp_lat, exp_lat - 1);
    end
    n_checks++;
    if (aw_cnt != 1 || w_cnt != 1) begin
      n_fail++; $display("FAIL %s_beats got aw=%0d w=%0d want aw=1 w=1", name, aw_cnt, w_cnt);
    end
    @(negedge clk);
    n_checks++;
    if (wready_o !== 1'b0 || awvalid_o !== 1'b0 || wvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL %s_pulse got wready=%b awvld=%b wvld=%b want 0 0 0", name, wready_o, awvalid_o, wvalid_o);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    lsu_avalid_i = 1'b1; ren_i = 1'b1; func3_i = F3_LW; addr_i = 32'h8000_0004;
    arready_i = 1'b1; rvalid_i = 1'b0; rdata_i = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    n_checks++;
    if (rready_o !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_in_rdata got rready=%b want 1", rready_o);
    end
    rst = 1'b0; lsu_avalid_i = 1'b0; ren_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, rvalid_o} !== 6'b0) begin
      n_fail++; $display("FAIL rstmid_clear got %b want 000000", {arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, rvalid_o});
    end
    rst = 1'b1; rvalid_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      n_checks++;
      if (rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin
        n_fail++; $display("FAIL rstmid_no_pulse got rvalid=%b data=%h want 0 00000000", rvalid_o, rdata_o);
      end
    end
    rvalid_i = 1'b0; arready_i = 1'b0;
    test_load("rstmid_after", F3_LW, 32'h8000_0008, 32'h1357_9BDF, 32'h1357_9BDF);
  endtask

  task automatic test_misalign();
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
    logic [31:0] prev;
    prev = rdata_o;
    @(negedge clk);
    lsu_avalid_i = 1'b1; ren_i = 1'b1; func3_i = F3_LW; addr_i = 32'h8000_0002;
    arready_i = 1'b1; rdata_i = 32'h1122_3344;
    @(negedge clk);
    lsu_avalid_i = 1'b0; ren_i = 1'b0;
    n_checks++;
    if (arvalid_o !== 1'b0 || rvalid_o !== 1'b1 || fault_o !== 1'b1 || rdata_o !== prev) begin
      n_fail++; $display("FAIL trap_done got arvld=%b rvalid=%b fault=%b data=%h want 0 1 1 %h",
                         arvalid_o, rvalid_o, fault_o, rdata_o, prev);
    end
    @(negedge clk);
    n_checks++;
    if (fault_o !== 1'b0 || rvalid_o !== 1'b0 || arvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL trap_after got fault=%b rvalid=%b arvld=%b want 0 0 0", fault_o, rvalid_o, arvalid_o);
    end
    arready_i = 1'b0;
`else
    test_load("misalign_lw", F3_LW, 32'h8000_0002, 32'h1122_3344, 32'h0000_1122);
`endif
  endtask

  initial begin
    test_reset();
    test_load("lb", F3_LB, 32'h8000_0003, 32'h80FF_1234, 32'hFFFF_FF80);
    test_load("lhu", F3_LHU, 32'h8000_0002, 32'h8001_7F00, 32'h0000_8001);
    test_load("lh", F3_LH, 32'h8000_0002, 32'h8001_7F00, 32'hFFFF_8001);
    test_load("lbu", F3_LBU, 32'h8000_0001, 32'h1234_F600, 32'h0000_00F6);
    test_store("sb", F3_SB, 32'h8000_0001, 32'h0000_00AB, 0, 0, 4'b0010, 32'h0000_AB00);
    test_store("sh", F3_SH, 32'h8000_0002, 32'h0000_1234, 0, 0, 4'b1100, 32'h1234_0000);
    test_store("sw_aw_first", F3_SW, 32'h8000_0010, 32'hDEAD_BEEF, 0, 1, 4'b1111, 32'hDEAD_BEEF);
    test_store("sw_w_first", F3_SW, 32'h8000_0014, 32'h0BAD_F00D, 1, 0, 4'b1111, 32'h0BAD_F00D);
    test_store("sw_same", F3_SW, 32'h8000_0018, 32'h5555_AAAA, 0, 0, 4'b1111, 32'h5555_AAAA);
    test_reset_mid();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
